// File: rtl/led_pattern_sequencer.sv
// 5-LED pattern sequencer: prescaled display tick, debounced mode button,
// four pattern generators (binary, Gray, rule-30 ring, knight-rider) and PWM gating.
module led_pattern_sequencer #(
   parameter int BITS      = 5,
   parameter int LOG2DELAY = 22,
   parameter int DEB_BITS  = 16,
   parameter int PWM_BITS  = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                btn,
   input  logic                mode_lock,
   input  logic [PWM_BITS-1:0] bright,
   output logic [BITS-1:0]     leds,
   output logic [1:0]          mode,
   output logic                tick
);

   typedef enum logic [1:0] {M_COUNT, M_GRAY, M_RANDOM, M_KNIGHT} mode_t;

   localparam int PW = (BITS > 1) ? $clog2(BITS) : 1;
   localparam logic [LOG2DELAY-1:0] PRE_ONE  = 1;
   localparam logic [DEB_BITS-1:0]  DEB_ONE  = 1;
   localparam logic [PWM_BITS-1:0]  PWM_ONE  = 1;
   localparam logic [BITS:0]        STEP_ONE = 1;
   localparam logic [PW-1:0]        POS_ONE  = 1;
   localparam logic [PW-1:0]        POS_MAX  = PW'(BITS - 1);
   localparam logic [BITS-1:0]      LED_ONE  = 1;

   logic [LOG2DELAY-1:0] prescaler;
   logic [BITS:0]        step;
   logic [31:0]          rng, rng_nx;
   logic [PW-1:0]        pos;
   logic                 dir_up;
   logic                 sync1, sync2, btn_db, btn_db_q;
   logic [DEB_BITS-1:0]  deb_cnt;
   logic [PWM_BITS-1:0]  pwm_cnt;
   mode_t                mode_q, mode_d;
   logic                 press, mode_chg, pwm_on;
   logic [BITS-1:0]      pattern;

   assign tick     = &prescaler;
   assign press    = btn_db & ~btn_db_q;
   assign mode_chg = press & ~mode_lock;
   assign mode     = mode_q;
   assign pwm_on   = (&bright) | (pwm_cnt < bright);

   // Rule 30 on a closed 32-bit ring
   always_comb begin
      rng_nx = '0;
      for (int i = 0; i < 32; i++)
         rng_nx[i] = rng[(i + 1) % 32] ^ (rng[i] | rng[(i + 31) % 32]);
   end

   always_comb begin
      mode_d = mode_q;
      if (mode_chg) begin
         case (mode_q)
            M_COUNT:  mode_d = M_GRAY;
            M_GRAY:   mode_d = M_RANDOM;
            M_RANDOM: mode_d = M_KNIGHT;
            default:  mode_d = M_COUNT;
         endcase
      end
   end

   always_comb begin
      pattern = '0;
      case (mode_q)
         M_COUNT:  pattern = step[BITS-1:0];
         M_GRAY:   pattern = step[BITS-1:0] ^ (step[BITS-1:0] >> 1);
         M_RANDOM: pattern = rng[BITS+6:7];
         default:  pattern = LED_ONE << pos;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) mode_q <= M_COUNT;
      else        mode_q <= mode_d;
   end

   // Synchroniser and debouncer; a press is the cycle after btn_db rises
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1    <= 1'b0;
         sync2    <= 1'b0;
         btn_db   <= 1'b0;
         btn_db_q <= 1'b0;
         deb_cnt  <= '0;
      end else begin
         sync1    <= btn;
         sync2    <= sync1;
         btn_db_q <= btn_db;
         if (sync2 == btn_db) begin
            deb_cnt <= '0;
         end else if (&deb_cnt) begin
            btn_db  <= sync2;
            deb_cnt <= '0;
         end else begin
            deb_cnt <= deb_cnt + DEB_ONE;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prescaler <= '0;
         pwm_cnt   <= '0;
         rng       <= 32'h0001_0000;
         step      <= '0;
         pos       <= '0;
         dir_up    <= 1'b1;
         leds      <= '0;
      end else begin
         prescaler <= prescaler + PRE_ONE;
         pwm_cnt   <= pwm_cnt + PWM_ONE;
         leds      <= pwm_on ? pattern : '0;
         if (tick) rng <= rng_nx;
         // A mode change overrides the tick for step and knight position
         if (mode_chg) begin
            step   <= '0;
            pos    <= '0;
            dir_up <= 1'b1;
         end else if (tick) begin
            step <= step + STEP_ONE;
            if (dir_up) begin
               if (pos == POS_MAX) begin
                  pos    <= pos - POS_ONE;
                  dir_up <= 1'b0;
               end else begin
                  pos <= pos + POS_ONE;
               end
            end else begin
               if (pos == '0) begin
                  pos    <= pos + POS_ONE;
                  dir_up <= 1'b1;
               end else begin
                  pos <= pos - POS_ONE;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Randomised scoreboard bench for led_pattern_sequencer with a word-level reference model.
module tb_led_pattern_sequencer;
   localparam int BITS = 5, L2D = 3, DEB = 2, PWB = 4;
   localparam int PMAX = (1 << L2D) - 1;
   localparam int DMAX = (1 << DEB) - 1;
   localparam int BMAX = (1 << PWB) - 1;
   localparam int NCYC = 4000;

   logic            clk = 1'b0, rst_n = 1'b0, btn = 1'b0, mode_lock = 1'b0;
   logic [PWB-1:0]  bright = '1;
   logic [BITS-1:0] leds;
   logic [1:0]      mode;
   logic            tick;

   led_pattern_sequencer #(.BITS(BITS), .LOG2DELAY(L2D), .DEB_BITS(DEB), .PWM_BITS(PWB)) dut (
      .clk(clk), .rst_n(rst_n), .btn(btn), .mode_lock(mode_lock),
      .bright(bright), .leds(leds), .mode(mode), .tick(tick));

   always #5 clk = ~clk;

   typedef struct packed {
      logic [BITS-1:0] leds;
      logic [1:0]      mode;
      logic            tick;
      logic [31:0]     rng;
   } exp_t;

   exp_t q[$];
   int   checks = 0, failures = 0;
   bit   started = 0;

   // reference state
   int          m_presc, m_step, m_kph, m_mode, m_s1, m_s2, m_db, m_dbq, m_dcnt, m_pwm;
   logic [31:0] m_rng;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         if (failures <= 20) $display("FAIL %s actual=%0h required=%0h", nm, act, req);
      end
   endtask

   function automatic logic [31:0] rule30(input logic [31:0] r);
      logic [31:0] right, left;
      right = {r[0], r[31:1]};   // bit i sees r[i+1]
      left  = {r[30:0], r[31]};  // bit i sees r[i-1]
      return right ^ (r | left);
   endfunction

   function automatic int knight_pos(input int ph);
      return (ph <= BITS - 1) ? ph : 2 * (BITS - 1) - ph;
   endfunction

   task automatic model_reset();
      m_presc = 0; m_step = 0; m_kph = 0; m_mode = 0; m_s1 = 0; m_s2 = 0;
      m_db = 0; m_dbq = 0; m_dcnt = 0; m_pwm = 0; m_rng = 32'h0001_0000;
   endtask

   task automatic push_exp(input int l);
      exp_t e;
      e.leds = l[BITS-1:0];
      e.mode = m_mode[1:0];
      e.tick = (m_presc == PMAX);
      e.rng  = m_rng;
      q.push_back(e);
      started = 1;
   endtask

   task automatic model_step();
      int tk, mc, s, pat, nl, db_n, dcnt_n;
      tk = (m_presc == PMAX);
      mc = (m_db == 1 && m_dbq == 0 && !mode_lock);
      s  = m_step % (1 << BITS);
      case (m_mode)
         0: pat = s;
         1: pat = s ^ (s >> 1);
         2: pat = int'(m_rng >> 7) % (1 << BITS);
         default: pat = 1 << knight_pos(m_kph);
      endcase
      nl = (bright == BMAX || m_pwm < int'(bright)) ? pat : 0;
      db_n = m_db; dcnt_n = 0;
      if (m_s2 != m_db) begin
         if (m_dcnt == DMAX) db_n = m_s2;
         else dcnt_n = m_dcnt + 1;
      end
      m_dbq = m_db; m_db = db_n; m_dcnt = dcnt_n;
      m_s2 = m_s1; m_s1 = int'(btn);
      m_presc = (m_presc + 1) % (PMAX + 1);
      m_pwm   = (m_pwm + 1) % (BMAX + 1);
      if (tk) m_rng = rule30(m_rng);
      if (mc) begin
         m_step = 0; m_kph = 0; m_mode = (m_mode + 1) % 4;
      end else if (tk) begin
         m_step = (m_step + 1) % (1 << (BITS + 1));
         m_kph  = (m_kph + 1) % (2 * (BITS - 1));
      end
      push_exp(nl);
   endtask

   // monitor
   always @(posedge clk) begin
      #1;
      if (q.size() != 0) begin
         exp_t e;
         e = q.pop_front();
         chk("leds", 32'(leds), 32'(e.leds));
         chk("mode", 32'(mode), 32'(e.mode));
         chk("tick", 32'(tick), 32'(e.tick));
         chk("rng",  dut.rng,   e.rng);
      end else if (started) begin
         chk("scoreboard_empty", 32'(q.size()), 32'd1);
      end
   end

   // driver
   initial begin
      int hold;
      hold = 0;
      model_reset();
      for (int cyc = 0; cyc < NCYC; cyc++) begin
         @(negedge clk);
         if (cyc < 3 || (cyc >= 2000 && cyc < 2003)) begin
            rst_n = 1'b0;
            if (cyc == 2000) begin
               #1;
               chk("async_rst_leds", 32'(leds), 32'd0);
               chk("async_rst_mode", 32'(mode), 32'd0);
               chk("async_rst_rng",  dut.rng,   32'h0001_0000);
            end
            model_reset();
            push_exp(0);
         end else begin
            rst_n = 1'b1;
            if (hold == 0) begin
               btn  = 1'($urandom_range(0, 1));
               hold = $urandom_range(1, 14);
            end
            hold--;
            if (cyc % 64 == 0) mode_lock = ($urandom_range(0, 3) == 0);
            if (cyc % 256 == 0) begin
               case ($urandom_range(0, 3))
                  0: bright = '0;
                  1: bright = 4'd4;
                  2: bright = '1;
                  default: bright = PWB'($urandom_range(0, BMAX));
               endcase
            end
            model_step();
         end
      end
      @(posedge clk);
      #2;
      started = 0;
      chk("scoreboard_drain", 32'(q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
